// File: rtl/pulse_spacer_if.sv
// Event/pulse bundle between the pulse spacer and its neighbours.
// ovf is present only when PULSE_SPACER_OVF_EN is defined.
interface pulse_spacer_if #(
  parameter int unsigned DEPTH_W = 4
);
  logic               e;
  logic               p;
  logic               busy;
  logic [DEPTH_W-1:0] cnt;
`ifdef PULSE_SPACER_OVF_EN
  logic               ovf;

  modport master (output e, input p, input busy, input cnt, input ovf);
  modport slave  (input e, output p, output busy, output cnt, output ovf);
`else
  modport master (output e, input p, input busy, input cnt);
  modport slave  (input e, output p, output busy, output cnt);
`endif
endinterface

// File: rtl/pulse_spacer.sv
// Converts async event edges into 1-clock pulses at least GAP clocks apart, queueing bursts.
// Optional sticky overflow flag enabled by defining PULSE_SPACER_OVF_EN.
module pulse_spacer #(
  parameter int unsigned GAP     = 32,
  parameter int unsigned DEPTH_W = 4
) (
  input logic           c,
  input logic           rn,
  pulse_spacer_if.slave bus
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [DEPTH_W-1:0] PndMax  = '1;
  localparam logic [7:0]         GapLoad = 8'(GAP - 1);

  logic [2:0]         r_sync;
  state_e             r_state, w_state_d;
  logic [7:0]         r_gap, w_gap_d;
  logic [DEPTH_W-1:0] r_pnd, w_pnd_d;
  logic               r_p, w_p_d;
  logic               w_ev;
  logic               w_have;
  logic               w_fire;

  // r_sync[0..2] are s0, s1, s2; edge detect uses only the settled stages.
  assign w_ev   = r_sync[1] & ~r_sync[2];
  assign w_have = w_ev | (r_pnd != '0);

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], bus.e};
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    w_p_d     = 1'b0;
    w_fire    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_have) w_fire = 1'b1;
      end
      StHold: begin
        if (r_gap != 8'd0) begin
          w_gap_d = r_gap - 8'd1;
        end else if (w_have) begin
          w_fire = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_fire) begin
      w_p_d     = 1'b1;
      w_gap_d   = GapLoad;
      w_state_d = StHold;
    end
  end

  // A fire consumes the live event when present, otherwise one queued event.
  always_comb begin
    w_pnd_d = r_pnd;
    if (w_ev && !w_fire) begin
      if (r_pnd != PndMax) w_pnd_d = r_pnd + 1'b1;
    end else if (!w_ev && w_fire) begin
      w_pnd_d = r_pnd - 1'b1;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      r_state <= StIdle;
      r_gap   <= 8'd0;
      r_pnd   <= '0;
      r_p     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_gap   <= w_gap_d;
      r_pnd   <= w_pnd_d;
      r_p     <= w_p_d;
    end
  end

  assign bus.p    = r_p;
  assign bus.cnt  = r_pnd;
  assign bus.busy = (r_state == StHold) | (r_pnd != '0);

`ifdef PULSE_SPACER_OVF_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = w_ev & ~w_fire & (r_pnd == PndMax);

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_drop;
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pulse_spacer.sv
// Directed bench for pulse_spacer: per-cycle logs of p/busy/cnt checked against hand-derived times.
module tb_pulse_spacer;
  localparam int unsigned GAP     = 32;
  localparam int unsigned DEPTH_W = 4;
  localparam int          MAXC    = 1024;

  logic c  = 1'b0;
  logic rn = 1'b0;
  always #5 c = ~c;

  pulse_spacer_if #(.DEPTH_W(DEPTH_W)) bus ();

  pulse_spacer #(.GAP(GAP), .DEPTH_W(DEPTH_W)) dut (
    .c   (c),
    .rn  (rn),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  bit   e_pat    [MAXC];
  logic p_log    [MAXC];
  logic busy_log [MAXC];
  int   cnt_log  [MAXC];
  int   ptimes   [$];

  task automatic clear_pat();
    for (int i = 0; i < MAXC; i++) e_pat[i] = 1'b0;
  endtask

  // e high for two samples starting at loop index k; first fire lands at k+3
  task automatic rise(input int k);
    e_pat[k]   = 1'b1;
    e_pat[k+1] = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge c);
      p_log[k]    = bus.p;
      busy_log[k] = bus.busy;
      cnt_log[k]  = int'(bus.cnt);
      bus.e       = e_pat[k];
    end
  endtask

  task automatic collect(input int n);
    ptimes.delete();
    for (int k = 0; k < n; k++) if (p_log[k] === 1'b1) ptimes.push_back(k);
  endtask

  function automatic int peak(input int n);
    int m = 0;
    for (int k = 0; k < n; k++) if (cnt_log[k] > m) m = cnt_log[k];
    return m;
  endfunction

  function automatic int pt(input int j);
    return (j < ptimes.size()) ? ptimes[j] : -1;
  endfunction

  task automatic do_reset();
    bus.e = 1'b0;
    rn    = 1'b0;
    repeat (3) @(negedge c);
    rn = 1'b1;
  endtask

  task automatic test_reset();
    bus.e = 1'b1;
    rn    = 1'b0;
    repeat (3) @(negedge c);
    n_vec++; if (bus.p !== 1'b0) begin n_bad++; $display("FAIL reset_p got %b want 0", bus.p); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", bus.cnt); end
`ifdef PULSE_SPACER_OVF_EN
    n_vec++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
    bus.e = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    clear_pat();
    rise(0);
    run(60);
    for (int k = 0; k < 60; k++) begin
      n_vec++;
      if (p_log[k] !== 1'(k == 3)) begin
        n_bad++; $display("FAIL single_p[%0d] got %b want %b", k, p_log[k], (k == 3));
      end
      n_vec++;
      if (busy_log[k] !== 1'(k >= 3 && k <= 34)) begin
        n_bad++; $display("FAIL single_busy[%0d] got %b want %b", k, busy_log[k], (k >= 3 && k <= 34));
      end
      n_vec++;
      if (cnt_log[k] !== 0) begin
        n_bad++; $display("FAIL single_cnt[%0d] got %0d want 0", k, cnt_log[k]);
      end
    end
  endtask

  task automatic test_burst3();
    do_reset();
    clear_pat();
    rise(0); rise(4); rise(8);
    run(110);
    collect(110);
    n_vec++; if (ptimes.size() != 3) begin n_bad++; $display("FAIL burst3_count got %0d want 3", ptimes.size()); end
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (pt(j) != 3 + 32 * j) begin n_bad++; $display("FAIL burst3_t%0d got %0d want %0d", j, pt(j), 3 + 32 * j); end
    end
    n_vec++; if (peak(110) != 2) begin n_bad++; $display("FAIL burst3_peak got %0d want 2", peak(110)); end
    n_vec++; if (busy_log[98] !== 1'b1) begin n_bad++; $display("FAIL burst3_busy98 got %b want 1", busy_log[98]); end
    n_vec++; if (busy_log[99] !== 1'b0) begin n_bad++; $display("FAIL burst3_busy99 got %b want 0", busy_log[99]); end
  endtask

  task automatic test_saturate();
    do_reset();
    clear_pat();
    for (int i = 0; i < 20; i++) rise(4 * i);
    run(620);
    collect(620);
    n_vec++; if (ptimes.size() != 18) begin n_bad++; $display("FAIL sat_count got %0d want 18", ptimes.size()); end
    for (int j = 0; j < 18; j++) begin
      n_vec++;
      if (pt(j) != 3 + 32 * j) begin n_bad++; $display("FAIL sat_t%0d got %0d want %0d", j, pt(j), 3 + 32 * j); end
    end
    n_vec++; if (peak(620) != 15) begin n_bad++; $display("FAIL sat_peak got %0d want 15", peak(620)); end
    n_vec++; if (cnt_log[80] != 15) begin n_bad++; $display("FAIL sat_hold got %0d want 15", cnt_log[80]); end
    n_vec++; if (busy_log[578] !== 1'b1) begin n_bad++; $display("FAIL sat_busy578 got %b want 1", busy_log[578]); end
    n_vec++; if (busy_log[579] !== 1'b0) begin n_bad++; $display("FAIL sat_busy579 got %b want 0", busy_log[579]); end
`ifdef PULSE_SPACER_OVF_EN
    n_vec++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", bus.ovf); end
`endif
  endtask

  task automatic test_coincide();
    do_reset();
    clear_pat();
    rise(0); rise(4); rise(8); rise(12); rise(32);
    run(180);
    collect(180);
    n_vec++; if (cnt_log[34] != 3) begin n_bad++; $display("FAIL coin_cnt34 got %0d want 3", cnt_log[34]); end
    n_vec++; if (p_log[35] !== 1'b1) begin n_bad++; $display("FAIL coin_p35 got %b want 1", p_log[35]); end
    n_vec++; if (cnt_log[35] != 3) begin n_bad++; $display("FAIL coin_cnt35 got %0d want 3", cnt_log[35]); end
    n_vec++; if (cnt_log[67] != 2) begin n_bad++; $display("FAIL coin_cnt67 got %0d want 2", cnt_log[67]); end
    n_vec++; if (ptimes.size() != 5) begin n_bad++; $display("FAIL coin_count got %0d want 5", ptimes.size()); end
    for (int j = 0; j < 5; j++) begin
      n_vec++;
      if (pt(j) != 3 + 32 * j) begin n_bad++; $display("FAIL coin_t%0d got %0d want %0d", j, pt(j), 3 + 32 * j); end
    end
    n_vec++; if (busy_log[162] !== 1'b1) begin n_bad++; $display("FAIL coin_busy162 got %b want 1", busy_log[162]); end
    n_vec++; if (busy_log[163] !== 1'b0) begin n_bad++; $display("FAIL coin_busy163 got %b want 0", busy_log[163]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_pat();
    for (int i = 0; i < 7; i++) rise(4 * i);
    run(36);
    n_vec++; if (p_log[35] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_p got %b want 1", p_log[35]); end
    n_vec++; if (cnt_log[35] != 5) begin n_bad++; $display("FAIL mid_pre_cnt got %0d want 5", cnt_log[35]); end
    n_vec++; if (busy_log[35] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_busy got %b want 1", busy_log[35]); end
    #2 rn = 1'b0;
    #1;
    n_vec++; if (bus.p !== 1'b0) begin n_bad++; $display("FAIL mid_rst_p got %b want 0", bus.p); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.cnt !== 4'd0) begin n_bad++; $display("FAIL mid_rst_cnt got %0d want 0", bus.cnt); end
    @(negedge c);
    rn = 1'b1;
    clear_pat();
    rise(0);
    run(50);
    collect(50);
    n_vec++; if (ptimes.size() != 1) begin n_bad++; $display("FAIL mid_post_count got %0d want 1", ptimes.size()); end
    n_vec++; if (pt(0) != 3) begin n_bad++; $display("FAIL mid_post_t got %0d want 3", pt(0)); end
    n_vec++; if (busy_log[34] !== 1'b1) begin n_bad++; $display("FAIL mid_post_busy34 got %b want 1", busy_log[34]); end
    n_vec++; if (busy_log[35] !== 1'b0) begin n_bad++; $display("FAIL mid_post_busy35 got %b want 0", busy_log[35]); end
  endtask

  task automatic test_hold_high();
    do_reset();
    clear_pat();
    for (int k = 0; k < 100; k++) e_pat[k] = 1'b1;
    run(200);
    collect(200);
    n_vec++; if (ptimes.size() != 1) begin n_bad++; $display("FAIL held_count got %0d want 1", ptimes.size()); end
    n_vec++; if (pt(0) != 3) begin n_bad++; $display("FAIL held_t got %0d want 3", pt(0)); end
    n_vec++; if (peak(200) != 0) begin n_bad++; $display("FAIL held_peak got %0d want 0", peak(200)); end
    n_vec++; if (busy_log[34] !== 1'b1) begin n_bad++; $display("FAIL held_busy34 got %b want 1", busy_log[34]); end
    n_vec++; if (busy_log[35] !== 1'b0) begin n_bad++; $display("FAIL held_busy35 got %b want 0", busy_log[35]); end
  endtask

  initial begin
    bus.e = 1'b0;
    test_reset();
    test_single();
    test_burst3();
    test_saturate();
    test_coincide();
    test_reset_mid();
    test_hold_high();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
